// File: rtl/game_pkg.sv
// Shared types and defaults for the game score datapath.
// State encoding, numerator width derivation and default timing constants.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_DIVIDE,
    ST_APPLY,
    ST_DONE
  } score_state_t;

  localparam int GRACE_S   = 60;
  localparam int LIMIT_S   = 1800;
  localparam int MAX_SCORE = 100;

  function automatic int num_w(input int timer_w, input int score_w);
    return timer_w + score_w;
  endfunction

endpackage

// File: rtl/game_score_engine_if.sv
// Score reporting bus from the score engine toward display/UART logic.
// Pure wires; no flow control, consumers sample the pulses as they occur.
interface game_score_if #(
  parameter int SCORE_W = 7
);
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic [SCORE_W-1:0] final_score;
  logic               final_valid;
  logic [SCORE_W-1:0] best_score;
  logic               new_record;

  modport master (
    output score, score_valid, final_score, final_valid, best_score, new_record
  );

  modport slave (
    input score, score_valid, final_score, final_valid, best_score, new_record
  );
endinterface

// File: rtl/game_score_engine_serial_divider.sv
// Restoring divider, one quotient bit per cycle; N_W cycles after start.
// done is high during the final iteration; quot is valid the following cycle.
module serial_divider #(
  parameter int N_W = 18,
  parameter int D_W = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] numer,
  input  logic [D_W-1:0] denom,
  output logic           done,
  output logic [N_W-1:0] quot
);
  localparam int CW = $clog2(N_W + 1);

  logic [N_W-1:0] quot_q, quot_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic [D_W-1:0] den_q, den_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [D_W:0]   rem_sh;
  logic [D_W-1:0] rem_sub;

  always_comb begin
    rem_sh  = {rem_q, quot_q[N_W-1]};
    rem_sub = rem_sh[D_W-1:0] - den_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      quot_d = numer;
      rem_d  = '0;
      den_d  = denom;
      cnt_d  = CW'(N_W);
    end else if (cnt_q != '0) begin
      // remainder stays below the divisor, so the subtraction fits D_W bits
      if (rem_sh >= {1'b0, den_q}) begin
        rem_d  = rem_sub;
        quot_d = {quot_q[N_W-2:0], 1'b1};
      end else begin
        rem_d  = rem_sh[D_W-1:0];
        quot_d = {quot_q[N_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign quot = quot_q;

endmodule

// File: rtl/game_score_engine.sv
// Time-decaying game score with penalties, win latch and per-level best score.
// Live score every NUM_W+2 cycles, final NUM_W+3 after a win; no backpressure.
module game_score_engine #(
  parameter int TIMER_W      = 11,
  parameter int SCORE_W      = 7,
  parameter int MAX_SCORE    = game_pkg::MAX_SCORE,
  parameter int GRACE_S      = game_pkg::GRACE_S,
  parameter int LIMIT_S      = game_pkg::LIMIT_S,
  parameter int ERR_PENALTY  = 5,
  parameter int HINT_PENALTY = 10,
  parameter int N_DIFF       = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [TIMER_W-1:0]        timer,
  input  logic                      playing_condition,
  input  logic                      error_pulse,
  input  logic                      hint_pulse,
  input  logic                      game_won,
  input  logic [$clog2(N_DIFF)-1:0] difficulty,
  game_score_if.master              rpt
);
  import game_pkg::*;

  localparam int NUM_W  = num_w(TIMER_W, SCORE_W);
  localparam int DIFF_W = $clog2(N_DIFF);
  localparam int PW     = SCORE_W + 8;
  localparam logic [TIMER_W-1:0] SPAN  = TIMER_W'(LIMIT_S - GRACE_S);
  localparam logic [TIMER_W-1:0] GRACE = TIMER_W'(GRACE_S);

  score_state_t       state_q, state_d;
  logic [3:0]         err_cnt_q, err_cnt_d, hint_cnt_q, hint_cnt_d;
  logic               win_pend_q, win_pend_d;
  logic [DIFF_W-1:0]  win_diff_q, win_diff_d;
  logic [TIMER_W-1:0] win_timer_q, win_timer_d;
  logic [SCORE_W-1:0] score_q, score_d, final_score_q, final_score_d;
  logic               score_valid_q, score_valid_d, final_valid_q, final_valid_d;
  logic               new_record_q, new_record_d;
  logic [SCORE_W-1:0] best_q [N_DIFF];
  logic [SCORE_W-1:0] best_d [N_DIFF];

  logic [TIMER_W-1:0] samp_timer, over, elapsed;
  logic [NUM_W-1:0]   numer, quot, t_full;
  logic [PW-1:0]      pen;
  logic [SCORE_W-1:0] result;
  logic               div_start, div_abort, div_done, cnt_ok;

  serial_divider #(.N_W(NUM_W), .D_W(TIMER_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .abort (div_abort),
    .numer (numer),
    .denom (SPAN),
    .done  (div_done),
    .quot  (quot)
  );

  // the win computation uses the timer captured in the game_won cycle
  always_comb begin
    samp_timer = win_pend_q ? win_timer_q : timer;
    over       = samp_timer - GRACE;
    if (samp_timer <= GRACE)  elapsed = '0;
    else if (over >= SPAN)    elapsed = SPAN;
    else                      elapsed = over;
    numer  = NUM_W'(elapsed) * NUM_W'(MAX_SCORE);
    t_full = NUM_W'(MAX_SCORE) - quot;
    pen    = PW'(err_cnt_q) * PW'(ERR_PENALTY) + PW'(hint_cnt_q) * PW'(HINT_PENALTY);
    result = (t_full > NUM_W'(pen)) ? SCORE_W'(t_full - NUM_W'(pen)) : '0;
  end

  always_comb begin
    state_d       = state_q;
    err_cnt_d     = err_cnt_q;
    hint_cnt_d    = hint_cnt_q;
    win_pend_d    = win_pend_q;
    win_diff_d    = win_diff_q;
    win_timer_d   = win_timer_q;
    score_d       = score_q;
    score_valid_d = 1'b0;
    final_score_d = final_score_q;
    final_valid_d = final_valid_q;
    new_record_d  = 1'b0;
    best_d        = best_q;
    div_start     = 1'b0;
    div_abort     = 1'b0;
    cnt_ok        = playing_condition && (state_q != ST_DONE);

    if (cnt_ok && error_pulse && err_cnt_q != 4'hf) err_cnt_d = err_cnt_q + 4'd1;
    if (cnt_ok && hint_pulse && hint_cnt_q != 4'hf) hint_cnt_d = hint_cnt_q + 4'd1;

    if (!playing_condition) begin
      state_d       = ST_IDLE;
      score_d       = '0;
      err_cnt_d     = '0;
      hint_cnt_d    = '0;
      win_pend_d    = 1'b0;
      final_valid_d = 1'b0;
      div_abort     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SAMPLE;
        ST_SAMPLE: begin
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
        end
        ST_DIVIDE: if (div_done) state_d = ST_APPLY;
        ST_APPLY: begin
          score_d       = result;
          score_valid_d = 1'b1;
          state_d       = ST_SAMPLE;
          if (win_pend_q) begin
            final_score_d = result;
            final_valid_d = 1'b1;
            win_pend_d    = 1'b0;
            state_d       = ST_DONE;
            if (int'(win_diff_q) < N_DIFF && result > best_q[win_diff_q]) begin
              best_d[win_diff_q] = result;
              new_record_d       = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase
      if (game_won && state_q != ST_DONE) begin
        win_pend_d  = 1'b1;
        win_diff_d  = difficulty;
        win_timer_d = timer;
        div_start   = 1'b0;
        div_abort   = 1'b1;
        state_d     = ST_SAMPLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      err_cnt_q     <= '0;
      hint_cnt_q    <= '0;
      win_pend_q    <= 1'b0;
      win_diff_q    <= '0;
      win_timer_q   <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      final_score_q <= '0;
      final_valid_q <= 1'b0;
      new_record_q  <= 1'b0;
      for (int i = 0; i < N_DIFF; i++) best_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      err_cnt_q     <= err_cnt_d;
      hint_cnt_q    <= hint_cnt_d;
      win_pend_q    <= win_pend_d;
      win_diff_q    <= win_diff_d;
      win_timer_q   <= win_timer_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      final_score_q <= final_score_d;
      final_valid_q <= final_valid_d;
      new_record_q  <= new_record_d;
      best_q        <= best_d;
    end
  end

  assign rpt.score       = score_q;
  assign rpt.score_valid = score_valid_q;
  assign rpt.final_score = final_score_q;
  assign rpt.final_valid = final_valid_q;
  assign rpt.new_record  = new_record_q;
  assign rpt.best_score  = (int'(difficulty) < N_DIFF) ? best_q[difficulty] : '0;

endmodule

// File: tb/tb_game_score_engine.sv
// Directed bench for game_score_engine with hand-computed scores and latencies.
module tb_game_score_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] timer;
  logic        playing_condition;
  logic        error_pulse;
  logic        hint_pulse;
  logic        game_won;
  logic [1:0]  difficulty;

  int n_checks = 0;
  int n_fail   = 0;

  game_score_if #(.SCORE_W(7)) rpt_if ();

  game_score_engine dut (
    .clk               (clk),
    .reset             (reset),
    .timer             (timer),
    .playing_condition (playing_condition),
    .error_pulse       (error_pulse),
    .hint_pulse        (hint_pulse),
    .game_won          (game_won),
    .difficulty        (difficulty),
    .rpt               (rpt_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns edges until score_valid, or -1 when the budget runs out
  task automatic wait_sv(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rpt_if.score_valid && n < 100);
    if (!rpt_if.score_valid) n = -1;
  endtask

  // game_won must already be asserted; counts from the game_won cycle
  task automatic pulse_win_wait_fv(output int n);
    tick();
    game_won = 1'b0;
    n = 1;
    while (!rpt_if.final_valid && n < 100) begin
      tick();
      n++;
    end
    if (!rpt_if.final_valid) n = -1;
  endtask

  task automatic restart(input logic [10:0] t);
    playing_condition = 1'b0;
    tick();
    tick();
    timer = t;
    playing_condition = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    playing_condition = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_checks++; if (rpt_if.score !== 7'd0) begin n_fail++; $display("FAIL reset_score got %0d want 0", rpt_if.score); end
    n_checks++; if (rpt_if.score_valid !== 1'b0) begin n_fail++; $display("FAIL reset_score_valid got %b want 0", rpt_if.score_valid); end
    n_checks++; if (rpt_if.final_score !== 7'd0) begin n_fail++; $display("FAIL reset_final_score got %0d want 0", rpt_if.final_score); end
    n_checks++; if (rpt_if.final_valid !== 1'b0) begin n_fail++; $display("FAIL reset_final_valid got %b want 0", rpt_if.final_valid); end
    n_checks++; if (rpt_if.best_score !== 7'd0) begin n_fail++; $display("FAIL reset_best got %0d want 0", rpt_if.best_score); end
    n_checks++; if (rpt_if.new_record !== 1'b0) begin n_fail++; $display("FAIL reset_new_record got %b want 0", rpt_if.new_record); end
  endtask

  task automatic test_live();
    int n;
    restart(11'd60);
    wait_sv(n);
    n_checks++; if (n !== 21) begin n_fail++; $display("FAIL live_first_latency got %0d want 21", n); end
    n_checks++; if (rpt_if.score !== 7'd100) begin n_fail++; $display("FAIL live_t60 got %0d want 100", rpt_if.score); end
    timer = 11'd930;
    wait_sv(n);
    n_checks++; if (n !== 20) begin n_fail++; $display("FAIL live_back_to_back got %0d want 20", n); end
    n_checks++; if (rpt_if.score !== 7'd50) begin n_fail++; $display("FAIL live_t930 got %0d want 50", rpt_if.score); end
    timer = 11'd2000;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd0) begin n_fail++; $display("FAIL live_t2000 got %0d want 0", rpt_if.score); end
    timer = 11'd1800;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd0) begin n_fail++; $display("FAIL live_t1800 got %0d want 0", rpt_if.score); end
    timer = 11'd30;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd100) begin n_fail++; $display("FAIL live_t30 got %0d want 100", rpt_if.score); end
    timer = 11'd120;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd97) begin n_fail++; $display("FAIL live_t120 got %0d want 97", rpt_if.score); end
  endtask

  task automatic test_penalties();
    int n;
    restart(11'd930);
    repeat (3) tick();
    error_pulse = 1'b1;
    repeat (2) tick();
    error_pulse = 1'b0;
    hint_pulse = 1'b1;
    tick();
    hint_pulse = 1'b0;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd30) begin n_fail++; $display("FAIL penalty_2e1h got %0d want 30", rpt_if.score); end
    error_pulse = 1'b1;
    repeat (20) tick();
    error_pulse = 1'b0;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd0) begin n_fail++; $display("FAIL penalty_underflow got %0d want 0", rpt_if.score); end
  endtask

  task automatic test_same_cycle();
    int n;
    restart(11'd930);
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd50) begin n_fail++; $display("FAIL same_cycle_base got %0d want 50", rpt_if.score); end
    error_pulse = 1'b1;
    hint_pulse  = 1'b1;
    tick();
    error_pulse = 1'b0;
    hint_pulse  = 1'b0;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd35) begin n_fail++; $display("FAIL same_cycle_both got %0d want 35", rpt_if.score); end
  endtask

  task automatic test_win_record();
    int n;
    int sv_cnt;
    int nr_cnt;
    difficulty = 2'd0;
    restart(11'd930);
    repeat (8) tick();
    timer = 11'd120;
    game_won = 1'b1;
    pulse_win_wait_fv(n);
    n_checks++; if (n !== 21) begin n_fail++; $display("FAIL win_latency got %0d want 21", n); end
    n_checks++; if (rpt_if.final_score !== 7'd97) begin n_fail++; $display("FAIL win_final got %0d want 97", rpt_if.final_score); end
    n_checks++; if (rpt_if.new_record !== 1'b1) begin n_fail++; $display("FAIL win_new_record got %b want 1", rpt_if.new_record); end
    n_checks++; if (rpt_if.best_score !== 7'd97) begin n_fail++; $display("FAIL win_best0 got %0d want 97", rpt_if.best_score); end
    n_checks++; if (rpt_if.score !== 7'd97) begin n_fail++; $display("FAIL win_score got %0d want 97", rpt_if.score); end
    tick();
    n_checks++; if (rpt_if.new_record !== 1'b0) begin n_fail++; $display("FAIL win_record_pulse got %b want 0", rpt_if.new_record); end
    // stimulus in DONE must be ignored
    sv_cnt = 0;
    nr_cnt = 0;
    timer = 11'd500;
    error_pulse = 1'b1;
    game_won = 1'b1;
    repeat (3) begin
      tick();
      if (rpt_if.score_valid) sv_cnt++;
      if (rpt_if.new_record) nr_cnt++;
    end
    error_pulse = 1'b0;
    game_won = 1'b0;
    repeat (30) begin
      tick();
      if (rpt_if.score_valid) sv_cnt++;
      if (rpt_if.new_record) nr_cnt++;
    end
    n_checks++; if (sv_cnt !== 0) begin n_fail++; $display("FAIL done_no_updates got %0d want 0", sv_cnt); end
    n_checks++; if (nr_cnt !== 0) begin n_fail++; $display("FAIL done_no_record got %0d want 0", nr_cnt); end
    n_checks++; if (rpt_if.score !== 7'd97) begin n_fail++; $display("FAIL done_frozen got %0d want 97", rpt_if.score); end
    n_checks++; if (rpt_if.final_score !== 7'd97) begin n_fail++; $display("FAIL done_final_kept got %0d want 97", rpt_if.final_score); end
    n_checks++; if (rpt_if.final_valid !== 1'b1) begin n_fail++; $display("FAIL done_final_valid got %b want 1", rpt_if.final_valid); end
  endtask

  task automatic test_win_no_record();
    int n;
    playing_condition = 1'b0;
    tick();
    n_checks++; if (rpt_if.final_valid !== 1'b0) begin n_fail++; $display("FAIL drop_final_valid got %b want 0", rpt_if.final_valid); end
    n_checks++; if (rpt_if.final_score !== 7'd97) begin n_fail++; $display("FAIL drop_final_kept got %0d want 97", rpt_if.final_score); end
    n_checks++; if (rpt_if.score !== 7'd0) begin n_fail++; $display("FAIL drop_score got %0d want 0", rpt_if.score); end
    tick();
    timer = 11'd300;
    playing_condition = 1'b1;
    wait_sv(n);
    n_checks++; if (rpt_if.score !== 7'd87) begin n_fail++; $display("FAIL live_t300 got %0d want 87", rpt_if.score); end
    game_won = 1'b1;
    pulse_win_wait_fv(n);
    n_checks++; if (n !== 21) begin n_fail++; $display("FAIL win2_latency got %0d want 21", n); end
    n_checks++; if (rpt_if.final_score !== 7'd87) begin n_fail++; $display("FAIL win2_final got %0d want 87", rpt_if.final_score); end
    n_checks++; if (rpt_if.new_record !== 1'b0) begin n_fail++; $display("FAIL win2_no_record got %b want 0", rpt_if.new_record); end
    n_checks++; if (rpt_if.best_score !== 7'd97) begin n_fail++; $display("FAIL win2_best0 got %0d want 97", rpt_if.best_score); end
    difficulty = 2'd1;
    #1;
    n_checks++; if (rpt_if.best_score !== 7'd0) begin n_fail++; $display("FAIL best1_empty got %0d want 0", rpt_if.best_score); end
    difficulty = 2'd0;
  endtask

  task automatic test_drop();
    int n;
    int sv_cnt;
    restart(11'd930);
    wait_sv(n);
    repeat (19) tick();
    playing_condition = 1'b0;
    tick();
    n_checks++; if (rpt_if.score_valid !== 1'b0) begin n_fail++; $display("FAIL drop_at_apply_valid got %b want 0", rpt_if.score_valid); end
    n_checks++; if (rpt_if.score !== 7'd0) begin n_fail++; $display("FAIL drop_at_apply_score got %0d want 0", rpt_if.score); end
    restart(11'd930);
    repeat (7) tick();
    playing_condition = 1'b0;
    sv_cnt = 0;
    repeat (25) begin
      tick();
      if (rpt_if.score_valid) sv_cnt++;
    end
    n_checks++; if (sv_cnt !== 0) begin n_fail++; $display("FAIL drop_mid_divide got %0d pulses want 0", sv_cnt); end
    n_checks++; if (rpt_if.best_score !== 7'd97) begin n_fail++; $display("FAIL drop_best_kept got %0d want 97", rpt_if.best_score); end
  endtask

  task automatic test_reset_mid_divide();
    int sv_cnt;
    restart(11'd930);
    repeat (9) tick();
    reset = 1'b1;
    playing_condition = 1'b0;
    tick();
    reset = 1'b0;
    n_checks++; if (rpt_if.score !== 7'd0) begin n_fail++; $display("FAIL rst_mid_score got %0d want 0", rpt_if.score); end
    n_checks++; if (rpt_if.best_score !== 7'd0) begin n_fail++; $display("FAIL rst_best_cleared got %0d want 0", rpt_if.best_score); end
    n_checks++; if (rpt_if.final_score !== 7'd0) begin n_fail++; $display("FAIL rst_final_cleared got %0d want 0", rpt_if.final_score); end
    sv_cnt = 0;
    repeat (25) begin
      tick();
      if (rpt_if.score_valid) sv_cnt++;
    end
    n_checks++; if (sv_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_valid got %0d pulses want 0", sv_cnt); end
  endtask

  initial begin
    reset             = 1'b1;
    timer             = '0;
    playing_condition = 1'b0;
    error_pulse       = 1'b0;
    hint_pulse        = 1'b0;
    game_won          = 1'b0;
    difficulty        = 2'd0;
    test_reset();
    test_live();
    test_penalties();
    test_same_cycle();
    test_win_record();
    test_win_no_record();
    test_drop();
    test_reset_mid_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_score_engine.md
# game_score_engine

Parametrised game-score unit for the sudoku datapath. It computes a time-decaying score between `GRACE_S` and `LIMIT_S` with a multi-cycle serial divider, so no combinational divide is needed. It subtracts error and hint penalties and latches a final score when the puzzle is won. It also keeps a best-score register per difficulty level. It sits between the game timer/FSM and the display/UART reporting logic.

## Interface
- `TIMER_W`, 11, timer width in seconds
- `SCORE_W`, 7, score width; must hold `MAX_SCORE`
- `MAX_SCORE`, 100, score at or below the grace time
- `GRACE_S`, 60, seconds of full score
- `LIMIT_S`, 1800, seconds at which the time score reaches 0; `LIMIT_S > GRACE_S`
- `ERR_PENALTY`, 5, points per error
- `HINT_PENALTY`, 10, points per hint
- `N_DIFF`, 3, difficulty levels with best-score slots
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `timer`  in  `TIMER_W`  elapsed seconds
- `playing_condition`  in  1  game in progress
- `error_pulse`  in  1  one-cycle pulse per wrong entry
- `hint_pulse`  in  1  one-cycle pulse per hint used
- `game_won`  in  1  one-cycle pulse when the puzzle is solved
- `difficulty`  in  `$clog2(N_DIFF)`  level; sampled on `game_won`
- `score`  out  `SCORE_W`  live score
- `score_valid`  out  1  one-cycle pulse when `score` updates
- `final_score`  out  `SCORE_W`  score latched at the win
- `final_valid`  out  1  level; a final score is held
- `best_score`  out  `SCORE_W`  best score for the current `difficulty`
- `new_record`  out  1  one-cycle pulse when the best score is beaten

## Operation
- **FSM states:** IDLE, SAMPLE, DIVIDE, APPLY, DONE.
- **IDLE:** if `playing_condition` is high, go to SAMPLE.
- **SAMPLE:** register the clamped elapsed time `e = min(max(timer-GRACE_S,0), LIMIT_S-GRACE_S)`. Load numerator `e*MAX_SCORE` (width `NUM_W = TIMER_W+SCORE_W`) and divisor `LIMIT_S-GRACE_S`.
- **DIVIDE:** restoring divider, one quotient bit per cycle, `NUM_W` cycles.
- **APPLY:** `t = MAX_SCORE - q`. Penalty `p = err_cnt*ERR_PENALTY + hint_cnt*HINT_PENALTY`, computed in `SCORE_W+8` bits. `score <= (t > p) ? t-p : 0`. Pulse `score_valid`.
  - Then go to SAMPLE if still playing and not winning, or to DONE if this was the win computation.
- Truncating division, so `timer=GRACE_S` gives `MAX_SCORE` and `timer>=LIMIT_S` gives 0. The path is uniform, with no shortcut.
- **Counters:** `err_cnt` and `hint_cnt` are 4-bit and saturate at 15. They count only while `playing_condition` is high and the FSM is not in DONE. If both pulses arrive in the same cycle, both counters increment. Counter values are read in the APPLY cycle.
- **`game_won` while playing and not in DONE:**
  - Abort any divide in progress.
  - Set `win_pend` and latch `difficulty`.
  - Force SAMPLE on the next cycle using the `timer` value present in the `game_won` cycle.
- **Win completion:** in APPLY with `win_pend` set:
  - `final_score <= result`; `final_valid <= 1`.
  - If `result > best[diff]` (strictly greater), update that slot and pulse `new_record`.
- **DONE:** `score` is frozen. `error_pulse`, `hint_pulse` and `game_won` are ignored.
- **`playing_condition` low, any state:** next cycle go to IDLE, `score=0`, counters=0, `win_pend=0`, `final_valid=0`. `final_score` and `best[]` are retained.
- `game_won` while not playing is ignored.
- `best_score = best[difficulty]`, a combinational read of the register file.

## Timing
- **Reset:** all outputs 0, `best[]` all 0, state IDLE, counters 0.
- **Live latency:** `timer` sampled in cycle t gives `score`/`score_valid` at t+`NUM_W`+2 (20 cycles at defaults). Updates then recur back-to-back every `NUM_W`+2 cycles.
- **Win latency:** `game_won` in cycle w gives `final_valid`, `final_score` and `new_record` at w+`NUM_W`+3 (21 at defaults).
- **Reset mid-divide:** the divide is abandoned with no `score_valid` pulse.
- **`playing_condition` drop in the same cycle as APPLY:** the drop wins; no pulse is issued and `score=0`.

## Structure
- **Shared package `game_pkg`:** state enum `score_state_t`, `NUM_W` derivation function, and default constants (`GRACE_S`, `LIMIT_S`, `MAX_SCORE`).
- **Sub-module `serial_divider`:** parametrised restoring divider with `start`, `abort` and `done`, plus quotient output. It is reusable elsewhere.
- The `best[]` register file stays inline.

## Test plan
- Defaults, `timer=60`, playing → `score=100` after 20 cycles; `timer=930` → 50; `timer=2000` → 0.
- `timer=930` with 2 `error_pulse` and 1 `hint_pulse` → `score=30`. Then 20 errors → `score=0` with no underflow.
- Error and hint pulsed in the same cycle → both counted: from 50, next `score=35`.
- `difficulty=0`, `game_won` at `timer=120` → `final_score=97`, `best[0]=97`, `new_record` pulse, `score` frozen. Drop and reassert `playing_condition`, win at `timer=300` → `final_score=87`, no record, `best[0]` stays 97.
- `game_won` mid-divide → abort and restart; final appears 21 cycles after the win. A second `game_won` in DONE is ignored.
- `reset` and a `playing_condition` drop mid-divide → no `score_valid`, `score=0` next cycle. After `reset` only, `best[]` is cleared.
